// File: rtl/hc86_tester.sv
// hc86_tester: exhaustive tester for a quad 2-input XOR (74HC86 footprint).
// Walks all 256 A/B combinations and waits a settle window for each one.
// Samples the synchronized Y pins and checks them against A^B.
// Reports per-gate sticky failure flags and a saturating error count.
// Also records the index of the first failing vector.
module hc86_tester #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] pin_y,
  output logic [3:0] pin_a,
  output logic [3:0] pin_b,
  output logic       pin_oe,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [7:0] err_cnt,
  output logic [7:0] first_fail_vec,
  output logic       first_fail_vld
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, FINISH} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] vec;
  logic [7:0] settle_cnt;
  logic [3:0] y_s1, y_s;
  logic [3:0] expected, mism;
  logic       run, accept, last_vec;

  assign run      = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
  assign accept   = (state == IDLE) && start && !abort;
  assign last_vec = (vec == 8'hFF);
  assign expected = vec[7:4] ^ vec[3:0];
  assign mism     = y_s ^ expected;

  assign busy   = run;
  assign pin_oe = run;
  assign done   = (state == FINISH);

  // Two-flop synchronizer for the asynchronous chip outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_s1 <= '0;
      y_s  <= '0;
    end else begin
      y_s1 <= pin_y;
      y_s  <= y_s1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort wins over every other transition while running
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DRIVE;
      DRIVE:   state_nxt = abort ? IDLE : SETTLE;
      SETTLE:  if (abort) state_nxt = IDLE;
               else if (settle_cnt == '0) state_nxt = SAMPLE;
      SAMPLE:  if (abort) state_nxt = IDLE;
               else state_nxt = last_vec ? FINISH : DRIVE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Vector sequencing, pin drive, settle timing and result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec            <= '0;
      settle_cnt     <= '0;
      pin_a          <= '0;
      pin_b          <= '0;
      pass           <= 1'b0;
      fail_mask      <= '0;
      err_cnt        <= '0;
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
    end else if (run && abort) begin
      // Partial fail_mask/err_cnt stay visible after an abort
      pin_a <= '0;
      pin_b <= '0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            vec            <= '0;
            pass           <= 1'b0;
            fail_mask      <= '0;
            err_cnt        <= '0;
            first_fail_vec <= '0;
            first_fail_vld <= 1'b0;
          end
        end
        DRIVE: begin
          pin_a      <= vec[7:4];
          pin_b      <= vec[3:0];
          settle_cnt <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 8'd1;
        end
        SAMPLE: begin
          fail_mask <= fail_mask | mism;
          if (mism != '0) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
            if (!first_fail_vld) begin
              first_fail_vec <= vec;
              first_fail_vld <= 1'b1;
            end
          end
          if (last_vec) begin
            // pass must include this final sample, so it is computed from the merged mask
            pass  <= ((fail_mask | mism) == '0);
            pin_a <= '0;
            pin_b <= '0;
          end else begin
            vec <= vec + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
